// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and ALU opcode encodings.
package cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // One-hot ALU opcodes
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] LS  = 4'b0100;
    localparam logic [3:0] RS  = 4'b1000;

endpackage

// File: rtl/reg_file_if.sv
// Decode/execute-side bus into the register file: write port, operand fetch and results.
interface reg_file_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              i_write_en;
    logic [ADDR_W-1:0] i_write_add;
    logic [DATA_W-1:0] i_write_data;
    logic              i_read_en;
    logic [ADDR_W-1:0] i_read_add_1;
    logic [ADDR_W-1:0] i_read_add_2;
    logic [ADDR_W-1:0] i_dest_add;
    logic [DATA_W-1:0] o_srcdata_1;
    logic [DATA_W-1:0] o_srcdata_2;
    logic              o_read_valid;
    logic              o_stall;

    modport master (
        output i_write_en, i_write_add, i_write_data,
        output i_read_en, i_read_add_1, i_read_add_2, i_dest_add,
        input  o_srcdata_1, o_srcdata_2, o_read_valid, o_stall
    );

    modport slave (
        input  i_write_en, i_write_add, i_write_data,
        input  i_read_en, i_read_add_1, i_read_add_2, i_dest_add,
        output o_srcdata_1, o_srcdata_2, o_read_valid, o_stall
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks destinations of issued instructions and flags RAW/WAW hazards.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_add_1,
    input  logic [ADDR_W-1:0] read_add_2,
    input  logic [ADDR_W-1:0] dest_add,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_add,
    output logic              stall,
    output logic              accept
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic             busy_1, busy_2, busy_d;

    // A write landing this cycle retires its pending mark early, so it never blocks.
    assign busy_1 = pending[read_add_1] & ~(write_en && (write_add == read_add_1));
    assign busy_2 = pending[read_add_2] & ~(write_en && (write_add == read_add_2));
    assign busy_d = pending[dest_add]   & ~(write_en && (write_add == dest_add));

    assign stall  = read_en & (busy_1 | busy_2 | busy_d);
    assign accept = read_en & ~stall;

    // Clear first, then set: a newly issued destination outranks a retiring write.
    always_comb begin
        pending_nxt = pending;
        if (write_en) pending_nxt[write_add] = 1'b0;
        if (accept)   pending_nxt[dest_add]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

endmodule

// File: rtl/reg_file.sv
// 2-read/1-write register file with same-cycle write forwarding and scoreboard-based stall.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic     i_clk,
    input  logic     i_reset,
    reg_file_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fwd_1, fwd_2;
    logic [DATA_W-1:0] srcdata_1, srcdata_2;
    logic              read_valid;
    logic              stall, accept;

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk        (i_clk),
        .reset      (i_reset),
        .read_en    (bus.i_read_en),
        .read_add_1 (bus.i_read_add_1),
        .read_add_2 (bus.i_read_add_2),
        .dest_add   (bus.i_dest_add),
        .write_en   (bus.i_write_en),
        .write_add  (bus.i_write_add),
        .stall      (stall),
        .accept     (accept)
    );

    // Each port independently picks up the in-flight write instead of the stale entry.
    assign fwd_1 = (bus.i_write_en && (bus.i_write_add == bus.i_read_add_1))
                   ? bus.i_write_data : mem[bus.i_read_add_1];
    assign fwd_2 = (bus.i_write_en && (bus.i_write_add == bus.i_read_add_2))
                   ? bus.i_write_data : mem[bus.i_read_add_2];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            srcdata_1  <= '0;
            srcdata_2  <= '0;
            read_valid <= 1'b0;
        end else begin
            if (bus.i_write_en) mem[bus.i_write_add] <= bus.i_write_data;
            read_valid <= accept;
            if (accept) begin
                srcdata_1 <= fwd_1;
                srcdata_2 <= fwd_2;
            end
        end
    end

    assign bus.o_srcdata_1  = srcdata_1;
    assign bus.o_srcdata_2  = srcdata_2;
    assign bus.o_read_valid = read_valid;
    assign bus.o_stall      = stall;

endmodule

// File: tb/tb_reg_file.sv
// Register-file bench: directed hazard/forwarding scenarios then random traffic vs. a reference model.
module tb_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    reg_file #(.DATA_W(8), .ADDR_W(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers, outstanding destinations, output latches
    logic [7:0] m_mem  [16];
    bit         m_pend [16];
    logic [7:0] m_s1, m_s2;
    bit         m_vld;
    bit         m_stall;
    logic       obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // An address blocks only if an issued instruction still owes it and no write retires it now.
    function automatic bit owed(input bit we, input int wa, input int a);
        return m_pend[a] && !(we && wa == a);
    endfunction

    task automatic cyc(input bit r, input bit we, input int wa, input int wd,
                       input bit re, input int a1, input int a2, input int d);
        bit acc;
        @(negedge clk);
        rst               = r;
        bus.i_write_en    = we;
        bus.i_write_add   = 4'(wa);
        bus.i_write_data  = 8'(wd);
        bus.i_read_en     = re;
        bus.i_read_add_1  = 4'(a1);
        bus.i_read_add_2  = 4'(a2);
        bus.i_dest_add    = 4'(d);
        #1;
        m_stall   = re && (owed(we, wa, a1) || owed(we, wa, a2) || owed(we, wa, d));
        obs_stall = bus.o_stall;
        chk("stall", {31'b0, obs_stall}, {31'b0, m_stall});
        @(posedge clk);
        #1;
        if (!r) begin
            foreach (m_mem[i]) begin m_mem[i] = '0; m_pend[i] = 0; end
            m_s1 = '0; m_s2 = '0; m_vld = 0;
        end else begin
            acc   = re && !m_stall;
            m_vld = acc;
            if (acc) begin
                m_s1 = (we && wa == a1) ? 8'(wd) : m_mem[a1];
                m_s2 = (we && wa == a2) ? 8'(wd) : m_mem[a2];
            end
            if (we) begin m_mem[wa] = 8'(wd); m_pend[wa] = 0; end
            if (acc) m_pend[d] = 1;
        end
        chk("srcdata_1",  {24'b0, bus.o_srcdata_1}, {24'b0, m_s1});
        chk("srcdata_2",  {24'b0, bus.o_srcdata_2}, {24'b0, m_s2});
        chk("read_valid", {31'b0, bus.o_read_valid}, {31'b0, m_vld});
    endtask

    initial begin
        foreach (m_mem[i]) begin m_mem[i] = 'x; m_pend[i] = 0; end
        bus.i_write_en = 0; bus.i_write_add = '0; bus.i_write_data = '0;
        bus.i_read_en = 0; bus.i_read_add_1 = '0; bus.i_read_add_2 = '0; bus.i_dest_add = '0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 8'h77, 1, 3, 3, 3);
        chk("reset_s1",  {24'b0, bus.o_srcdata_1}, 32'h0);
        chk("reset_vld", {31'b0, bus.o_read_valid}, 32'h0);

        // reset, read r3/r5
        cyc(1, 0, 0, 0, 1, 3, 5, 15);
        chk("r3r5_s1",  {24'b0, bus.o_srcdata_1}, 32'h0);
        chk("r3r5_s2",  {24'b0, bus.o_srcdata_2}, 32'h0);
        chk("r3r5_vld", {31'b0, bus.o_read_valid}, 32'h1);
        cyc(1, 1, 15, 0, 0, 0, 0, 0);

        // write then read next cycle, and same-cycle forwarding
        cyc(1, 1, 3, 8'h2A, 1, 3, 0, 14);
        chk("fwd_r3", {24'b0, bus.o_srcdata_1}, 32'h2A);
        cyc(1, 1, 14, 8'h01, 1, 3, 14, 12);
        chk("rd_r3",   {24'b0, bus.o_srcdata_1}, 32'h2A);
        chk("fwd_r14", {24'b0, bus.o_srcdata_2}, 32'h01);
        cyc(1, 1, 12, 0, 0, 0, 0, 0);

        // RAW hazard on r7
        cyc(1, 0, 0, 0, 1, 0, 0, 7);
        cyc(1, 0, 0, 0, 1, 7, 0, 6);
        chk("r7_stall", {31'b0, obs_stall}, 32'h1);
        chk("r7_novld", {31'b0, bus.o_read_valid}, 32'h0);
        cyc(1, 1, 7, 8'h05, 1, 7, 0, 6);
        chk("r7_release", {31'b0, obs_stall}, 32'h0);
        chk("r7_data",    {24'b0, bus.o_srcdata_1}, 32'h05);
        cyc(1, 1, 6, 8'h06, 0, 0, 0, 0);

        // set beats clear on r4
        cyc(1, 1, 4, 8'h11, 1, 0, 0, 4);
        cyc(1, 0, 0, 0, 1, 4, 0, 13);
        chk("r4_stall", {31'b0, obs_stall}, 32'h1);
        cyc(1, 1, 4, 8'h22, 1, 4, 0, 13);
        chk("r4_data", {24'b0, bus.o_srcdata_1}, 32'h22);
        cyc(1, 1, 13, 0, 0, 0, 0, 0);

        // reset mid-operation
        cyc(1, 1, 9, 8'hFF, 1, 0, 0, 2);
        cyc(0, 1, 9, 8'h33, 1, 9, 0, 5);
        cyc(1, 0, 0, 0, 1, 9, 2, 8);
        chk("rst_nostall", {31'b0, obs_stall}, 32'h0);
        chk("rst_r9",      {24'b0, bus.o_srcdata_1}, 32'h0);
        cyc(1, 1, 8, 0, 0, 0, 0, 0);

        // zero write clears pending
        cyc(1, 1, 1, 8'h5A, 1, 0, 0, 1);
        cyc(1, 1, 1, 8'h00, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 1, 10);
        chk("r1_nostall", {31'b0, obs_stall}, 32'h0);
        chk("r1_zero",    {24'b0, bus.o_srcdata_1}, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(99) >= 2), ($urandom_range(99) < 45), $urandom_range(15),
                $urandom_range(255), ($urandom_range(99) < 70), $urandom_range(15),
                $urandom_range(15), $urandom_range(15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
